neural_net_core: RTL and testbench

- Fixed-point feed-forward neural-network inference engine: N_IN signed Q16.16 inputs → one hidden layer (N_HID neurons, ReLU) → one linear output neuron.
- Sits downstream of the memory reader that supplies the input vector `ins`.
- Produces `outs[0]`, the network score.
- Time-multiplexed: one multiplier, a small FSM, weights held as package constants.

---
 rtl/nn_pkg.sv | 48 ++++
 rtl/neural_net_core_q16_mac.sv | 20 ++
 rtl/neural_net_core.sv | 117 +++++++++++
 tb/tb_neural_net_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types, network constants and Q16.16 helpers
// for the neural_net_core inference engine.
package nn_pkg;

  localparam int N_IN  = 7;
  localparam int N_HID = 4;
  localparam int FRAC  = 16;

  localparam int CW = $clog2(N_IN + 1);
  localparam int JW = $clog2(N_HID);

  typedef logic signed [31:0] q16_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HID,
    S_OUT,
    S_DONE
  } state_t;

  localparam q16_t ONE = 32'sh0001_0000;
  localparam q16_t ZRO = 32'sh0000_0000;

  // Hidden neuron j sums the inputs whose index is j modulo 4.
  localparam q16_t W_HID [N_HID][N_IN] = '{
    '{ONE, ZRO, ZRO, ZRO, ONE, ZRO, ZRO},
    '{ZRO, ONE, ZRO, ZRO, ZRO, ONE, ZRO},
    '{ZRO, ZRO, ONE, ZRO, ZRO, ZRO, ONE},
    '{ZRO, ZRO, ZRO, ONE, ZRO, ZRO, ZRO}
  };

  localparam q16_t B_HID [N_HID] = '{ZRO, ZRO, ZRO, ZRO};
  localparam q16_t W_OUT [N_HID] = '{ONE, ONE, ONE, ONE};
  localparam q16_t B_OUT = ZRO;

  function automatic q16_t sat_add(input q16_t a, input q16_t b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  function automatic q16_t relu(input q16_t a);
    return a[31] ? ZRO : a;
  endfunction

endpackage

// File: rtl/neural_net_core_q16_mac.sv
// Combinational Q16.16 multiply-accumulate with a
// saturating 32-bit accumulator.
module q16_mac
  import nn_pkg::*;
(
  input  q16_t a,
  input  q16_t b,
  input  q16_t acc,
  output q16_t res
);

  logic signed [63:0] prod;
  q16_t scaled;

  // Floor shift, then keep the low word without saturating.
  assign prod   = a * b;
  assign scaled = 32'(prod >>> FRAC);
  assign res    = sat_add(acc, scaled);

endmodule

// File: rtl/neural_net_core.sv
// Time-multiplexed single-hidden-layer Q16.16 network:
// one MAC, ReLU hidden layer, linear output neuron.
module neural_net_core
  import nn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  q16_t ins [N_IN],
  input  logic in_valid,
  output logic in_ready,
  output q16_t outs [1],
  output logic out_valid
);

  localparam logic [CW-1:0] IN_END  = CW'(N_IN);
  localparam logic [CW-1:0] HID_END = CW'(N_HID);
  localparam logic [JW-1:0] J_LAST  = JW'(N_HID - 1);

  state_t state, state_nx;

  q16_t x [N_IN];
  q16_t h [N_HID];
  q16_t acc, res, outs_q;
  q16_t mul_a, mul_b;

  logic [CW-1:0] cnt, in_idx;
  logic [JW-1:0] j, j_nx, hid_idx;
  logic fire;

  assign fire      = in_valid && (state == S_IDLE);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign outs[0]   = outs_q;
  assign j_nx      = j + JW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_HID;
      S_HID:  if (cnt == IN_END && j == J_LAST)
                state_nx = S_OUT;
      S_OUT:  if (cnt == HID_END) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_idx  = (cnt < IN_END) ? cnt : '0;
    hid_idx = cnt[JW-1:0];
    mul_a   = ZRO;
    mul_b   = ZRO;
    unique case (1'b1)
      state == S_HID: begin
        mul_a = x[in_idx];
        mul_b = W_HID[j][in_idx];
      end
      state == S_OUT: begin
        mul_a = h[hid_idx];
        mul_b = W_OUT[hid_idx];
      end
      default: ;
    endcase
  end

  q16_mac u_mac (
    .a   (mul_a),
    .b   (mul_b),
    .acc (acc),
    .res (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) x[i] <= ZRO;
      for (int k = 0; k < N_HID; k++) h[k] <= ZRO;
      acc    <= ZRO;
      outs_q <= ZRO;
      cnt    <= '0;
      j      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (fire) begin
          for (int i = 0; i < N_IN; i++) x[i] <= ins[i];
          acc <= sat_add(ZRO, B_HID[0]);
          cnt <= '0;
          j   <= '0;
        end
        S_HID: if (cnt == IN_END) begin
          h[j] <= relu(acc);
          cnt  <= '0;
          j    <= j_nx;
          acc  <= (j == J_LAST) ? sat_add(ZRO, B_OUT)
                                : sat_add(ZRO, B_HID[j_nx]);
        end else begin
          acc <= res;
          cnt <= cnt + CW'(1);
        end
        S_OUT: if (cnt == HID_END) begin
          outs_q <= acc;
          cnt    <= '0;
        end else begin
          acc <= res;
          cnt <= cnt + CW'(1);
        end
        S_DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_net_core.sv
// Directed and randomized checks of neural_net_core
// against an arithmetic reference of the network.
module tb_neural_net_core;
  import nn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  q16_t ins [N_IN];
  logic in_valid, in_ready, out_valid;
  q16_t outs [1];

  int checks = 0;
  int errors = 0;

  neural_net_core dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outs      (outs),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -MAXV - 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sadd(input longint a, input longint b);
    longint s;
    s = a + b;
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic longint qmul(input longint a, input longint b);
    longint p;
    logic signed [31:0] lo;
    p  = (a * b) >>> 16;
    lo = p[31:0];
    return longint'(lo);
  endfunction

  function automatic logic [31:0] model(input q16_t v [N_IN]);
    longint acc, w;
    longint hid [N_HID];
    for (int jj = 0; jj < N_HID; jj++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        w   = (i % 4 == jj) ? 65536 : 0;
        acc = sadd(acc, qmul(longint'(v[i]), w));
      end
      hid[jj] = (acc < 0) ? 0 : acc;
    end
    acc = 0;
    for (int jj = 0; jj < N_HID; jj++)
      acc = sadd(acc, qmul(hid[jj], 65536));
    return acc[31:0];
  endfunction

  task automatic set_all(input q16_t v);
    for (int i = 0; i < N_IN; i++) ins[i] = v;
  endtask

  task automatic randomize_ins();
    for (int i = 0; i < N_IN; i++)
      if ($urandom_range(0, 3) == 0)
        ins[i] = q16_t'($urandom);
      else
        ins[i] = q16_t'($urandom_range(0, 32'h0010_0000))
               - 32'sh0008_0000;
  endtask

  // Called at a negedge; returns cycles until out_valid is seen.
  task automatic launch(input bit hold, input bit disturb,
                        output int n);
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) in_valid = disturb && n >= 5 && n < 8;
      if (disturb && n == 5) randomize_ins();
    end while (!out_valid && n < 80);
  endtask

  task automatic run(input string tag, input bit disturb);
    logic [31:0] exp;
    int n;
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    exp = model(ins);
    launch(1'b0, disturb, n);
    chk({tag, ".lat"}, n, 32'd38);
    chk({tag, ".out"}, outs[0], exp);
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
    chk({tag, ".hold"}, outs[0], exp);
  endtask

  initial begin
    int n, seen;
    logic [31:0] exp;
    q16_t v2 [N_IN];

    rst = 1'b1;
    in_valid = 1'b0;
    set_all(ONE);
    #7;
    chk("rst.outs", outs[0], 32'h0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(in_ready), 32'd1);

    set_all(ONE);
    chk("ones.model", model(ins), 32'h0007_0000);
    run("ones", 1'b0);

    set_all(ZRO);
    ins[0] = 32'shFFFD_0000;
    ins[4] = ONE;
    run("relu", 1'b0);
    chk("relu.value", outs[0], 32'h0);

    set_all(ZRO);
    ins[0] = 32'sh7FFF_0000;
    ins[4] = 32'sh7FFF_0000;
    run("sat", 1'b0);
    chk("sat.value", outs[0], 32'h7FFF_FFFF);

    set_all(ZRO);
    ins[0] = 32'sh0000_8000;
    run("latch", 1'b1);
    chk("latch.value", outs[0], 32'h0000_8000);

    randomize_ins();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 2; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.outs", outs[0], 32'h0);
    chk("abort.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort.quiet", seen, 32'd0);
    chk("abort.outs2", outs[0], 32'h0);
    set_all(ONE);
    run("fresh", 1'b0);

    for (int t = 0; t < 6; t++) begin
      randomize_ins();
      run($sformatf("rnd%0d", t), t[0]);
    end

    randomize_ins();
    exp = model(ins);
    launch(1'b1, 1'b0, n);
    chk("b2b.lat1", n, 32'd38);
    chk("b2b.out1", outs[0], exp);
    randomize_ins();
    v2 = ins;
    launch(1'b1, 1'b0, n);
    in_valid = 1'b0;
    chk("b2b.lat2", n, 32'd39);
    chk("b2b.out2", outs[0], model(v2));
    @(negedge clk);
    @(negedge clk);
    chk("b2b.idle", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
